// File: rtl/mod_updown_counter.sv
// Parametrised synchronous up/down counter: wrap or saturate, clamped load, terminal-count pulse and sticky overflow.
// Optional step prescaler is built only when CNT_PRESCALE_EN is defined.
module mod_updown_counter #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit              SATURATE = 1'b0,
    parameter int              PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_max
);

    if (WIDTH < 1 || WIDTH > 32 || MAX_VAL == '0 || PRESCALE < 2) begin : g_bad_param
        $error("mod_updown_counter: illegal parameter combination");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_step;
    logic             w_at_zero;
    logic             w_at_max;
    logic             w_term;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        if (val > MAX_VAL) begin
            return MAX_VAL;
        end else begin
            return val;
        end
    endfunction

`ifdef CNT_PRESCALE_EN
    localparam int             PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_ps;

    assign w_step = en && (r_ps == PS_LAST);

    // Prescaler: advances only while enabled, restarts on clear/load/reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ps <= '0;
        end else if (clr || load) begin
            r_ps <= '0;
        end else if (en) begin
            if (r_ps == PS_LAST) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + 1'b1;
            end
        end else begin
            r_ps <= r_ps;
        end
    end
`else
    assign w_step = en;
`endif

    // Compares stay in WIDTH bits so MAX_VAL = all-ones cannot overflow.
    assign w_at_zero = (r_count == '0);
    assign w_at_max  = (r_count == MAX_VAL);
    assign w_term    = up ? w_at_max : w_at_zero;

    // Next-state selection in priority order clr > load > step > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = clamp_load(load_val);
        end else if (w_step) begin
            if (w_term) begin
                w_tc_nxt = 1'b1;
                if (SATURATE) begin
                    w_count_nxt = r_count;
                end else if (up) begin
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = MAX_VAL;
                end
            end else if (up) begin
                w_count_nxt = r_count + 1'b1;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
        end else begin
            w_count_nxt = r_count;
        end
        // A terminal event outranks a simultaneous ovf_clr.
        if (w_tc_nxt) begin
            w_ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign ovf     = r_ovf;
    assign at_zero = w_at_zero;
    assign at_max  = w_at_max;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter: wrap, saturate and 8-bit instances.
// Prescaler checks are selected when CNT_PRESCALE_EN is defined.
module tb_mod_updown_counter;

    logic       clk;
    logic       rn_a, rn_b, rn_c;
    logic       en, up, clr, load, ovf_clr;
    logic [7:0] load_val;

    logic [3:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       tc_a, ovf_a, az_a, am_a;
    logic       tc_b, ovf_b, az_b, am_b;
    logic       tc_c, ovf_c, az_c, am_c;

    int err_cnt = 0;
    int chk_cnt = 0;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .PRESCALE(4)) u_wrap (
        .clk(clk), .reset_n(rn_a), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(cnt_a), .tc(tc_a),
        .ovf(ovf_a), .at_zero(az_a), .at_max(am_a));

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .PRESCALE(4)) u_sat (
        .clk(clk), .reset_n(rn_b), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .count(cnt_b), .tc(tc_b),
        .ovf(ovf_b), .at_zero(az_b), .at_max(am_b));

    mod_updown_counter #(.WIDTH(8), .MAX_VAL(8'd255), .SATURATE(1'b0), .PRESCALE(4)) u_w8 (
        .clk(clk), .reset_n(rn_c), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr), .count(cnt_c), .tc(tc_c),
        .ovf(ovf_c), .at_zero(az_c), .at_max(am_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; ovf_clr = 1'b0; load_val = 8'd0;
        tick();
        tick();
        check_eq("rst_cnt_a", {28'd0, cnt_a}, 32'd0);
        check_eq("rst_tc_a",  {31'd0, tc_a},  32'd0);
        check_eq("rst_ovf_a", {31'd0, ovf_a}, 32'd0);
        check_eq("rst_az_a",  {31'd0, az_a},  32'd1);
        check_eq("rst_am_a",  {31'd0, am_a},  32'd0);
        check_eq("rst_cnt_b", {28'd0, cnt_b}, 32'd0);
        check_eq("rst_cnt_c", {24'd0, cnt_c}, 32'd0);
        check_eq("rst_ovf_c", {31'd0, ovf_c}, 32'd0);

`ifdef CNT_PRESCALE_EN
        // PRESCALE=4: steps on every 4th enabled edge
        rn_a = 1'b1; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq($sformatf("ps_run_%0d", k), {28'd0, cnt_a}, k / 4);
        end
        // en low for 3 cycles in the middle delays the next step by 3 cycles
        tick(); check_eq("ps_gap_1", {28'd0, cnt_a}, 32'd2);
        tick(); check_eq("ps_gap_2", {28'd0, cnt_a}, 32'd2);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("ps_frozen_%0d", k), {28'd0, cnt_a}, 32'd2);
        end
        en = 1'b1;
        tick(); check_eq("ps_gap_3", {28'd0, cnt_a}, 32'd2);
        tick(); check_eq("ps_gap_step", {28'd0, cnt_a}, 32'd3);
        // load mid-prescale restarts the divider
        tick(); check_eq("ps_pre_load", {28'd0, cnt_a}, 32'd3);
        load = 1'b1; load_val = 8'd5;
        tick(); check_eq("ps_load", {28'd0, cnt_a}, 32'd5);
        load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("ps_after_load_%0d", k), {28'd0, cnt_a}, 32'd5);
        end
        tick(); check_eq("ps_after_load_4", {28'd0, cnt_a}, 32'd6);
        check_eq("ps_tc", {31'd0, tc_a}, 32'd0);
`else
        // wrap counter, counting up 0..9,0,1
        rn_a = 1'b1; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_eq($sformatf("up_cnt_%0d", k), {28'd0, cnt_a}, k % 10);
            check_eq($sformatf("up_tc_%0d", k),  {31'd0, tc_a},  (k == 10) ? 32'd1 : 32'd0);
            check_eq($sformatf("up_ovf_%0d", k), {31'd0, ovf_a}, (k >= 10) ? 32'd1 : 32'd0);
            check_eq($sformatf("up_am_%0d", k),  {31'd0, am_a},  (k == 9) ? 32'd1 : 32'd0);
        end
        // clr leaves ovf alone
        clr = 1'b1;
        tick();
        check_eq("clr_cnt", {28'd0, cnt_a}, 32'd0);
        check_eq("clr_ovf", {31'd0, ovf_a}, 32'd1);
        clr = 1'b0; en = 1'b0; ovf_clr = 1'b1;
        tick();
        check_eq("ovfclr", {31'd0, ovf_a}, 32'd0);
        ovf_clr = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        check_eq("dn_wrap_cnt", {28'd0, cnt_a}, 32'd9);
        check_eq("dn_wrap_tc",  {31'd0, tc_a},  32'd1);
        check_eq("dn_wrap_ovf", {31'd0, ovf_a}, 32'd1);
        tick();
        check_eq("dn_8", {28'd0, cnt_a}, 32'd8);
        check_eq("dn_8_tc", {31'd0, tc_a}, 32'd0);
        tick();
        ovf_clr = 1'b1;
        tick();
        check_eq("dn_6", {28'd0, cnt_a}, 32'd6);
        check_eq("dn_6_ovf", {31'd0, ovf_a}, 32'd0);
        ovf_clr = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            tick();
            check_eq($sformatf("dn_cnt_%0d", k), {28'd0, cnt_a}, k);
        end
        check_eq("dn_zero_az", {31'd0, az_a}, 32'd1);
        // terminal event and ovf_clr together: set wins
        ovf_clr = 1'b1;
        tick();
        check_eq("set_wins_ovf", {31'd0, ovf_a}, 32'd1);
        check_eq("set_wins_tc",  {31'd0, tc_a},  32'd1);
        check_eq("set_wins_cnt", {28'd0, cnt_a}, 32'd9);
        ovf_clr = 1'b0;
        // priority clr > load > step
        clr = 1'b1; load = 1'b1; load_val = 8'd5; en = 1'b1; up = 1'b1;
        tick();
        check_eq("prio_clr", {28'd0, cnt_a}, 32'd0);
        check_eq("prio_clr_tc", {31'd0, tc_a}, 32'd0);
        clr = 1'b0;
        tick();
        check_eq("prio_load", {28'd0, cnt_a}, 32'd5);
        rn_a = 1'b0;
        tick();
        check_eq("prio_rst_cnt", {28'd0, cnt_a}, 32'd0);
        check_eq("prio_rst_ovf", {31'd0, ovf_a}, 32'd0);
        // saturating counter: clamped load then hold at max
        rn_b = 1'b1; load = 1'b1; load_val = 8'd12; en = 1'b0;
        tick();
        check_eq("sat_clamp", {28'd0, cnt_b}, 32'd9);
        check_eq("sat_clamp_tc", {31'd0, tc_b}, 32'd0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("sat_hold_%0d", k), {28'd0, cnt_b}, 32'd9);
            check_eq($sformatf("sat_tc_%0d", k),   {31'd0, tc_b},  32'd1);
            check_eq($sformatf("sat_am_%0d", k),   {31'd0, am_b},  32'd1);
            check_eq($sformatf("sat_ovf_%0d", k),  {31'd0, ovf_b}, 32'd1);
        end
        up = 1'b0;
        tick();
        check_eq("sat_dir_cnt", {28'd0, cnt_b}, 32'd8);
        check_eq("sat_dir_tc",  {31'd0, tc_b},  32'd0);
        load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0;
        tick();
        check_eq("sat_low_cnt", {28'd0, cnt_b}, 32'd0);
        check_eq("sat_low_tc",  {31'd0, tc_b},  32'd1);
        // 8-bit full range: compare at 255 must not overflow
        rn_b = 1'b0; rn_c = 1'b1; load = 1'b1; load_val = 8'd254; en = 1'b0; up = 1'b1;
        tick();
        check_eq("w8_load", {24'd0, cnt_c}, 32'd254);
        check_eq("w8_am_254", {31'd0, am_c}, 32'd0);
        load = 1'b0; en = 1'b1;
        tick();
        check_eq("w8_255", {24'd0, cnt_c}, 32'd255);
        check_eq("w8_am_255", {31'd0, am_c}, 32'd1);
        check_eq("w8_tc_255", {31'd0, tc_c}, 32'd0);
        tick();
        check_eq("w8_wrap", {24'd0, cnt_c}, 32'd0);
        check_eq("w8_wrap_tc", {31'd0, tc_c}, 32'd1);
        check_eq("w8_wrap_ovf", {31'd0, ovf_c}, 32'd1);
        check_eq("w8_wrap_az", {31'd0, az_c}, 32'd1);
        en = 1'b0;
        tick();
        check_eq("w8_hold", {24'd0, cnt_c}, 32'd0);
        check_eq("w8_hold_tc", {31'd0, tc_c}, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
